// File: rtl/arb_pkg.sv
// Shared types and default widths for the processor/host RAM arbiter.
package arb_pkg;

    localparam int unsigned ARB_AW           = 9;
    localparam int unsigned ARB_DW           = 9;
    localparam int unsigned ARB_HOST_QUANTUM = 16;

    typedef enum logic {
        S_CPU  = 1'b0,
        S_HOST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational 2:1 select of the single RAM port between processor and host.
module mem_port_mux
    import arb_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
) (
    input  logic          sel_host,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_d,
    input  logic          cpu_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_d,
    input  logic          host_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    output logic          mem_we
);

    always_comb begin
        mem_addr = cpu_addr;
        mem_d    = cpu_d;
        mem_we   = cpu_we;
        if (sel_host) begin
            mem_addr = host_addr;
            mem_d    = host_wdata_sel(host_d);
            mem_we   = host_we;
        end
    end

    function automatic logic [DW-1:0] host_wdata_sel(input logic [DW-1:0] d);
        return d;
    endfunction

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between the processor and a host req/gnt port.
// Optional host time-slicing is enabled by defining ARB_FAIRNESS_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned AW           = ARB_AW,
    parameter int unsigned DW           = ARB_DW,
    parameter int unsigned HOST_QUANTUM = ARB_HOST_QUANTUM
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          run_en,
    input  logic          cpu_done,
    output logic          Run,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    input  logic          cpu_w,
    output logic [DW-1:0] cpu_din,
    input  logic          host_req,
    output logic          host_gnt,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q
);

    if (HOST_QUANTUM == 0) begin : g_bad_quantum
        $error("mem_arbiter: HOST_QUANTUM must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic       cpu_busy_q, cpu_busy_d;
    logic       host_rvalid_q, host_rvalid_d;
    logic       owed_c;
    logic       quantum_end_c;
    logic       switch_c;
    logic       host_rd_c;
    logic       host_wr_c;

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned QW = (HOST_QUANTUM > 1) ? $clog2(HOST_QUANTUM) : 1;

    logic [QW-1:0] qcnt_q, qcnt_d;
    logic          owed_q, owed_d;

    assign owed_c        = owed_q;
    assign quantum_end_c = (qcnt_q == QW'(HOST_QUANTUM - 1));

    // Host slot counter; owed guarantees the processor one instruction after a forced return.
    always_comb begin
        qcnt_d = qcnt_q;
        owed_d = owed_q;
        if (cpu_done || !run_en) begin
            owed_d = 1'b0;
        end
        if (state_q == S_CPU) begin
            qcnt_d = '0;
        end else begin
            qcnt_d = qcnt_q + QW'(1);
            if (quantum_end_c) begin
                owed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            qcnt_q <= '0;
            owed_q <= 1'b0;
        end else begin
            qcnt_q <= qcnt_d;
            owed_q <= owed_d;
        end
    end
`else
    assign owed_c        = 1'b0;
    assign quantum_end_c = 1'b0;
`endif

    // Run is held low in the cycle ownership moves so the processor stays in T0.
    always_comb begin
        switch_c  = (state_q == S_CPU) && host_req && !cpu_busy_q && !owed_c;
        Run       = run_en && (state_q == S_CPU) && !switch_c;
        host_gnt  = (state_q == S_HOST) && host_req;
        host_rd_c = host_gnt && host_valid && !host_we;
        host_wr_c = host_gnt && host_valid && host_we;
    end

    always_comb begin
        state_d       = state_q;
        cpu_busy_d    = cpu_busy_q;
        host_rvalid_d = host_rd_c;

        if (cpu_done) begin
            cpu_busy_d = 1'b0;
        end else if ((state_q == S_CPU) && Run && !cpu_busy_q) begin
            cpu_busy_d = 1'b1;
        end

        case (state_q)
            S_CPU: begin
                if (switch_c) begin
                    state_d = S_HOST;
                end
            end
            S_HOST: begin
                if (!host_req || quantum_end_c) begin
                    state_d = S_CPU;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= S_CPU;
            cpu_busy_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_busy_q    <= cpu_busy_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    mem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .sel_host  (state_q == S_HOST),
        .cpu_addr  (cpu_addr),
        .cpu_d     (cpu_dout),
        .cpu_we    (cpu_w),
        .host_addr (host_addr),
        .host_d    (host_wdata),
        .host_we   (host_wr_c),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_we    (mem_we)
    );

    // Read data goes straight from the RAM to both requesters.
    assign cpu_din     = mem_q;
    assign host_rdata  = mem_q;
    assign host_rvalid = host_rvalid_q;

endmodule
